// File: rtl/sport_ram_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: default widths and FSM state encoding.
package sport_pkg;

   localparam int AW_DEF = 3;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/sport_ram_arb_if.sv
// Requester A/B handshakes, the RAM-side port and the status outputs of the arbiter.
interface sport_ram_arb_if
   import sport_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) ();

   logic          a_req;
   logic          b_req;
   logic          a_we;
   logic          b_we;
   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] a_wdata;
   logic [DW-1:0] b_wdata;
   logic          a_ack;
   logic          b_ack;
   logic [DW-1:0] a_rdata;
   logic [DW-1:0] b_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_wenable;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;
   logic          busy;
   logic [1:0]    grant;

   // Arbiter side
   modport slave (
      input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_data_out,
      output a_ack, b_ack, a_rdata, b_rdata, ram_addr, ram_wenable, ram_data_in, busy, grant
   );

   // Requesters plus the RAM model
   modport master (
      output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, ram_data_out,
      input  a_ack, b_ack, a_rdata, b_rdata, ram_addr, ram_wenable, ram_data_in, busy, grant
   );

endinterface

// File: rtl/sport_ram_arb_rr_arb2.sv
// Combinational two-way round-robin pick; pointer=0 gives A priority, 1 gives B.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic [1:0] winner
);

   // A lone requester wins outright; on contention the pointer decides.
   always_comb begin
      winner = req;
      if (req == 2'b11) begin
         winner = pointer ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/sport_ram_arb.sv
// Two-requester arbiter in front of a single-port RAM: IDLE -> ACCESS -> RESP, one access per 3 cycles.
module sport_ram_arb
   import sport_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic            clock,
   input  logic            reset,
   sport_ram_arb_if.slave  bus
);

   state_t        state;
   logic          ptr;
   logic          lat_we;
   logic [1:0]    win;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   rr_arb2 u_arb (
      .req     ({bus.b_req, bus.a_req}),
      .pointer (ptr),
      .winner  (win)
   );

   // Route the winning requester's fields toward the RAM registers.
   always_comb begin
      sel_we    = bus.a_we;
      sel_addr  = bus.a_addr;
      sel_wdata = bus.a_wdata;
      if (win[1]) begin
         sel_we    = bus.b_we;
         sel_addr  = bus.b_addr;
         sel_wdata = bus.b_wdata;
      end
   end

   // Access sequencer; ack and read data are registered at the end of RESP.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ptr             <= 1'b0;
         lat_we          <= 1'b0;
         bus.a_ack       <= 1'b0;
         bus.b_ack       <= 1'b0;
         bus.a_rdata     <= '0;
         bus.b_rdata     <= '0;
         bus.ram_addr    <= '0;
         bus.ram_wenable <= 1'b0;
         bus.ram_data_in <= '0;
         bus.busy        <= 1'b0;
         bus.grant       <= '0;
      end else begin
         bus.a_ack <= 1'b0;
         bus.b_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (|win) begin
                  bus.grant       <= win;
                  bus.ram_addr    <= sel_addr;
                  bus.ram_data_in <= sel_wdata;
                  bus.ram_wenable <= sel_we;
                  lat_we          <= sel_we;
                  bus.busy        <= 1'b1;
                  state           <= ACCESS;
               end
            end
            ACCESS: begin
               bus.ram_wenable <= 1'b0;
               state           <= RESP;
            end
            RESP: begin
               bus.a_ack <= bus.grant[0];
               bus.b_ack <= bus.grant[1];
               if (!lat_we) begin
                  if (bus.grant[0]) bus.a_rdata <= bus.ram_data_out;
                  if (bus.grant[1]) bus.b_rdata <= bus.ram_data_out;
               end
               // Priority passes to whoever did not just win.
               ptr             <= bus.grant[0];
               bus.ram_wenable <= 1'b0;
               bus.grant       <= '0;
               bus.busy        <= 1'b0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
